// File: rtl/cortexm0_rst_seq_ctl.sv
// Reset sequencer: synchronised global reset, timed hold, staggered domain release, per-domain re-reset.
// Latency: domain i released MIN_ASSERT+i*STAGE_GAP cycles after sync; requests act on the next edge.
// Backpressure: none; requests are sampled every cycle and folded into the running sequence.
module cortexm0_rst_seq_ctl #(
  parameter int NUM_DOM     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic               FCLK,
  input  logic               GLOBALRESETn,
  input  logic [NUM_DOM-1:0] RSTREQ,
  input  logic               RSTBYPASS,
  input  logic               SE,
  output logic [NUM_DOM-1:0] RSTOUTn,
  output logic [NUM_DOM-1:0] RSTACK,
  output logic               BUSY
);

  localparam int CNT_MAX = (MIN_ASSERT > STAGE_GAP) ? MIN_ASSERT : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  // The FSM register leaving SYNC acts as the final synchroniser stage,
  // so only SYNC_STAGES-1 dedicated flops are needed here.
  localparam int SW      = SYNC_STAGES - 1;

  localparam logic [PW-1:0] LAST_DOM = PW'(NUM_DOM - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t               state_q, nxt_state;
  logic [SW-1:0]        sync_q;
  logic [PW-1:0]        ptr_q, nxt_ptr;
  logic [CW-1:0]        cnt_q, nxt_cnt;
  logic [NUM_DOM-1:0]   rst_q, nxt_rst;
  logic [NUM_DOM-1:0]   mask_q, nxt_mask;
  logic [NUM_DOM-1:0]   ack_q, nxt_ack;
  logic [NUM_DOM-1:0]   req_eff;
  logic                 req_any;
  logic [PW-1:0]        req_lo;
  logic                 rel_now;

  // Deassertion synchroniser: async clear, shifts ones in after GLOBALRESETn rises.
  always_ff @(posedge FCLK or negedge GLOBALRESETn) begin
    if (!GLOBALRESETn) sync_q <= '0;
    else               sync_q <= (sync_q << 1) | SW'(1);
  end

  // Scan enable masks requests; find the lowest requested domain.
  always_comb begin
    req_eff = SE ? '0 : RSTREQ;
    req_any = |req_eff;
    req_lo  = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (req_eff[i]) req_lo = PW'(i);
    end
  end

  // State register.
  always_ff @(posedge FCLK or negedge GLOBALRESETn) begin
    if (!GLOBALRESETn) state_q <= ST_SYNC;
    else               state_q <= nxt_state;
  end

  // Next-state and datapath decisions; a request always overrides a release in the same cycle.
  always_comb begin
    nxt_state = state_q;
    nxt_ptr   = ptr_q;
    nxt_cnt   = cnt_q;
    nxt_rst   = rst_q;
    nxt_mask  = mask_q;
    nxt_ack   = '0;
    rel_now   = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (sync_q[SW-1]) begin
          nxt_state = ST_HOLD;
          nxt_ptr   = '0;
          nxt_cnt   = '0;
        end
      end
      ST_HOLD:    rel_now = (cnt_q == HOLD_END);
      ST_RELEASE: rel_now = (cnt_q == GAP_END);
      default:    rel_now = 1'b0;
    endcase

    if (state_q == ST_HOLD || state_q == ST_RELEASE) begin
      nxt_cnt = cnt_q + CW'(1);
      if (rel_now) begin
        nxt_rst[ptr_q] = 1'b1;
        nxt_cnt        = '0;
        if (ptr_q == LAST_DOM) begin
          nxt_state = ST_RUN;
          nxt_ack   = mask_q;
          nxt_mask  = '0;
        end else begin
          nxt_state = ST_RELEASE;
          nxt_ptr   = ptr_q + PW'(1);
        end
      end
    end

    if (state_q != ST_SYNC && req_any) begin
      nxt_mask = mask_q | req_eff;
      nxt_ack  = '0;
      if (state_q == ST_RUN || req_lo < ptr_q) begin
        // Requested domain already running: pull it and every dependent domain low.
        nxt_state = ST_HOLD;
        nxt_ptr   = req_lo;
        nxt_cnt   = '0;
        nxt_rst   = rst_q;
        for (int i = 0; i < NUM_DOM; i++) begin
          if (i >= int'(req_lo)) nxt_rst[i] = 1'b0;
        end
      end else if (req_lo == ptr_q && (state_q == ST_HOLD || rel_now)) begin
        // Domain still low: a held request pins the hold timer at zero.
        nxt_state = ST_HOLD;
        nxt_ptr   = ptr_q;
        nxt_cnt   = '0;
        nxt_rst   = rst_q;
      end
    end
  end

  // Datapath registers: pointer, counter, domain resets, ack mask and ack pulse.
  always_ff @(posedge FCLK or negedge GLOBALRESETn) begin
    if (!GLOBALRESETn) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      rst_q  <= '0;
      mask_q <= '0;
      ack_q  <= '0;
    end else begin
      ptr_q  <= nxt_ptr;
      cnt_q  <= nxt_cnt;
      rst_q  <= nxt_rst;
      mask_q <= nxt_mask;
      ack_q  <= nxt_ack;
    end
  end

  // Outputs; bypass drives resets straight from the global pin for DFT.
  always_comb begin
    RSTOUTn = RSTBYPASS ? {NUM_DOM{GLOBALRESETn}} : rst_q;
    RSTACK  = ack_q;
    BUSY    = (state_q != ST_RUN);
  end

endmodule
